// File: rtl/wb_pkg.sv
// Shared types and default sizing for the write-back arbiter and its load tracking queue.
package wb_pkg;

    localparam int unsigned WB_DEPTH = 2;
    localparam int unsigned WB_XLEN  = 32;
    localparam int unsigned WB_NREG  = 32;
    localparam int unsigned WB_PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;

    typedef struct packed {
        logic               valid;
        logic               filled;
        logic [4:0]         rd;
        logic [WB_XLEN-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_track_q.sv
// Circular queue of outstanding loads: in-order allocation, in-order fill, head retire, busy vector.
module wb_track_q
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = WB_DEPTH,
    parameter int unsigned XLEN  = WB_XLEN
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_push,
    input  logic [4:0]         i_push_rd,
    input  logic               i_rsp,
    input  logic [XLEN-1:0]    i_rsp_data,
    input  logic               i_pop,
    output logic               o_ready,
    output wb_entry_t          o_head,
    output logic [WB_NREG-1:0] o_busy
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    wb_entry_t        r_q [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W-1:0] r_fill;
    logic [CNT_W-1:0] r_count;

    logic             w_push;
    logic             w_fill;
    logic [WB_NREG-1:0] w_busy;

    function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        o_ready = (r_count < CNT_W'(DEPTH));
        w_push  = i_push && o_ready;
        // the fill pointer always names the oldest unfilled entry, if any
        w_fill  = i_rsp && r_q[r_fill].valid && !r_q[r_fill].filled;
        o_head  = r_q[r_head];
    end

    always_comb begin
        w_busy = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (r_q[i].valid && (r_q[i].rd != 5'd0)) begin
                w_busy[r_q[i].rd] = 1'b1;
            end
        end
        o_busy = w_busy;
    end

    // pop is applied after fill so a same-cycle bypassed head ends up invalid
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_q[i] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_fill  <= '0;
            r_count <= '0;
        end else begin
            if (w_fill) begin
                r_q[r_fill].filled <= 1'b1;
                r_q[r_fill].data   <= WB_XLEN'(i_rsp_data);
                r_fill             <= f_inc(r_fill);
            end
            if (i_pop) begin
                r_q[r_head].valid  <= 1'b0;
                r_q[r_head].filled <= 1'b0;
                r_head             <= f_inc(r_head);
            end
            if (w_push) begin
                r_q[r_tail] <= '{valid: 1'b1, filled: 1'b0, rd: i_push_rd, data: '0};
                r_tail      <= f_inc(r_tail);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(i_pop);
        end
    end

`ifndef SYNTHESIS
    a_rsp_has_entry: assert property (@(posedge clk) disable iff (!reset)
        i_rsp |-> (r_q[r_fill].valid && !r_q[r_fill].filled));
`endif

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter (ALU over loads) with load scoreboard stall.
// Optional WB_BYPASS_EN: a response for an unfilled head writes through in the same cycle.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = WB_DEPTH,
    parameter int unsigned XLEN  = WB_XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_wr_i,
    input  logic [4:0]      alu_waddr_i,
    input  logic [XLEN-1:0] alu_wdata_i,
    input  logic            ld_issue_i,
    input  logic [4:0]      ld_rd_i,
    output logic            ld_issue_ready_o,
    input  logic            ld_rsp_valid_i,
    input  logic [XLEN-1:0] ld_rsp_data_i,
    input  logic [4:0]      rs1_i,
    input  logic [4:0]      rs2_i,
    input  logic [4:0]      rd_i,
    output logic            stall_o,
    output logic            reg_wr_c,
    output logic [4:0]      waddr_o,
    output logic [XLEN-1:0] wdata_o
);

    wb_entry_t          w_head;
    logic [WB_NREG-1:0] w_busy;
    logic               w_ready;
    logic               w_alu;
    logic               w_byp;
    logic               w_retire;

    wb_track_q #(.DEPTH(DEPTH), .XLEN(XLEN)) u_track_q (
        .clk        (clk),
        .reset      (reset),
        .i_push     (ld_issue_i),
        .i_push_rd  (ld_rd_i),
        .i_rsp      (ld_rsp_valid_i),
        .i_rsp_data (ld_rsp_data_i),
        .i_pop      (w_retire),
        .o_ready    (w_ready),
        .o_head     (w_head),
        .o_busy     (w_busy)
    );

    // an x0 ALU write frees the port for the head entry
    always_comb begin
        w_alu = alu_wr_i && (alu_waddr_i != 5'd0);
`ifdef WB_BYPASS_EN
        w_byp = !w_alu && w_head.valid && !w_head.filled && ld_rsp_valid_i;
`else
        w_byp = 1'b0;
`endif
        w_retire = (!w_alu && w_head.valid && w_head.filled) || w_byp;
    end

    always_comb begin
        reg_wr_c = w_alu || (w_retire && (w_head.rd != 5'd0));
        waddr_o  = w_alu ? alu_waddr_i : w_head.rd;
        if (w_alu) begin
            wdata_o = alu_wdata_i;
        end else if (w_byp) begin
            wdata_o = ld_rsp_data_i;
        end else begin
            wdata_o = XLEN'(w_head.data);
        end
    end

    always_comb begin
        ld_issue_ready_o = w_ready;
        stall_o          = w_busy[rs1_i] | w_busy[rs2_i] | w_busy[rd_i];
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic against a queue-level model.
module tb_wb_arbiter;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned XLEN  = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            alu_wr_i;
    logic [4:0]      alu_waddr_i;
    logic [XLEN-1:0] alu_wdata_i;
    logic            ld_issue_i;
    logic [4:0]      ld_rd_i;
    logic            ld_issue_ready_o;
    logic            ld_rsp_valid_i;
    logic [XLEN-1:0] ld_rsp_data_i;
    logic [4:0]      rs1_i, rs2_i, rd_i;
    logic            stall_o;
    logic            reg_wr_c;
    logic [4:0]      waddr_o;
    logic [XLEN-1:0] wdata_o;

    always #5 clk = ~clk;

    wb_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk              (clk),
        .reset            (reset),
        .alu_wr_i         (alu_wr_i),
        .alu_waddr_i      (alu_waddr_i),
        .alu_wdata_i      (alu_wdata_i),
        .ld_issue_i       (ld_issue_i),
        .ld_rd_i          (ld_rd_i),
        .ld_issue_ready_o (ld_issue_ready_o),
        .ld_rsp_valid_i   (ld_rsp_valid_i),
        .ld_rsp_data_i    (ld_rsp_data_i),
        .rs1_i            (rs1_i),
        .rs2_i            (rs2_i),
        .rd_i             (rd_i),
        .stall_o          (stall_o),
        .reg_wr_c         (reg_wr_c),
        .waddr_o          (waddr_o),
        .wdata_o          (wdata_o)
    );

    typedef struct {
        logic [4:0]  rd;
        logic        filled;
        logic [31:0] data;
    } ld_t;

    ld_t         mq[$];
    logic [31:0] rf [32];
    int          n_checks = 0;
    int          n_errors = 0;
    logic        d_ret, d_push, d_rsp;
    logic [31:0] d_rsp_data;
    int          d_fill_idx;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic m_busy(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].rd == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_first_unfilled();
        foreach (mq[i]) if (!mq[i].filled) return i;
        return -1;
    endfunction

    // drive one cycle's inputs, then compare every output with the model
    task automatic drive(input logic aw, input logic [4:0] wa, input logic [31:0] wd,
                         input logic iss, input logic [4:0] ird,
                         input logic rsp, input logic [31:0] rdat,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] dd);
        logic alu, byp, e_wr;
        logic [4:0] e_addr;
        logic [31:0] e_data;
        alu_wr_i = aw; alu_waddr_i = wa; alu_wdata_i = wd;
        ld_issue_i = iss; ld_rd_i = ird;
        ld_rsp_valid_i = rsp; ld_rsp_data_i = rdat;
        rs1_i = s1; rs2_i = s2; rd_i = dd;
        #2;
        alu = aw && (wa != 5'd0);
        byp = 1'b0;
        d_ret = 1'b0;
        if (!alu && mq.size() > 0) begin
            d_ret = mq[0].filled;
`ifdef WB_BYPASS_EN
            byp = !mq[0].filled && rsp;
            d_ret = d_ret || byp;
`endif
        end
        e_wr = alu || (d_ret && mq[0].rd != 5'd0);
        e_addr = alu ? wa : (mq.size() > 0 ? mq[0].rd : 5'd0);
        e_data = alu ? wd : (byp ? rdat : (mq.size() > 0 ? mq[0].data : 32'd0));
        chk("ready", 64'(ld_issue_ready_o), 64'(mq.size() < DEPTH));
        chk("stall", 64'(stall_o), 64'(m_busy(s1) | m_busy(s2) | m_busy(dd)));
        chk("reg_wr", 64'(reg_wr_c), 64'(e_wr));
        if (e_wr) begin
            chk("waddr", 64'(waddr_o), 64'(e_addr));
            chk("wdata", 64'(wdata_o), 64'(e_data));
        end
        if (reg_wr_c === 1'b1) rf[waddr_o] = wdata_o;
        d_push = iss && (mq.size() < DEPTH);
        d_rsp = rsp;
        d_rsp_data = rdat;
        d_fill_idx = m_first_unfilled();
    endtask

    task automatic tick();
        ld_t e;
        @(posedge clk);
        if (d_rsp && d_fill_idx >= 0) begin
            mq[d_fill_idx].filled = 1'b1;
            mq[d_fill_idx].data = d_rsp_data;
        end
        if (d_ret) void'(mq.pop_front());
        if (d_push) begin
            e.rd = ld_rd_i; e.filled = 1'b0; e.data = 32'd0;
            mq.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic [4:0] s1);
        drive(0, 0, 0, 0, 0, 0, 0, s1, 0, 0);
    endtask

    initial begin
        foreach (rf[i]) rf[i] = 32'd0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        idle(0);
        chk("rst_ready", 64'(ld_issue_ready_o), 64'd1);
        chk("rst_stall", 64'(stall_o), 64'd0);
        reset = 1'b1;
        tick();

        // ALU only
        drive(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
        chk("alu_wr", 64'(reg_wr_c), 64'd1);
        chk("alu_addr", 64'(waddr_o), 64'd5);
        chk("alu_data", 64'(wdata_o), 64'hDEADBEEF);
        tick();
        drive(1, 5'd0, 32'h12345678, 0, 0, 0, 0, 0, 0, 0);
        chk("alu_x0", 64'(reg_wr_c), 64'd0);
        tick();

        // load RAW stall
        drive(0, 0, 0, 1, 5'd7, 0, 0, 0, 0, 0); tick();
        idle(5'd7);
        chk("raw_stall", 64'(stall_o), 64'd1);
        tick();
        drive(0, 0, 0, 0, 0, 1, 32'h1234, 5'd7, 0, 0);
`ifdef WB_BYPASS_EN
        chk("raw_byp_wr", 64'(reg_wr_c), 64'd1);
        chk("raw_byp_data", 64'(wdata_o), 64'h1234);
        tick();
`else
        chk("raw_wr_early", 64'(reg_wr_c), 64'd0);
        tick();
        idle(5'd7);
        chk("raw_wr", 64'(reg_wr_c), 64'd1);
        chk("raw_addr", 64'(waddr_o), 64'd7);
        chk("raw_data", 64'(wdata_o), 64'h1234);
        tick();
`endif
        idle(5'd7);
        chk("raw_unstall", 64'(stall_o), 64'd0);
        tick();

        // port conflict: ALU holds the port while the head is filled
        drive(0, 0, 0, 1, 5'd3, 0, 0, 0, 0, 0); tick();
        drive(1, 5'd4, 32'h55, 0, 0, 1, 32'hAA, 0, 0, 0);
        chk("pc_addr0", 64'(waddr_o), 64'd4);
        tick();
        for (int k = 1; k < 3; k++) begin
            drive(1, 5'd4, 32'h55, 0, 0, 0, 0, 0, 0, 0);
            chk("pc_addr", 64'(waddr_o), 64'd4);
            tick();
        end
        idle(0);
        chk("pc_head_wr", 64'(reg_wr_c), 64'd1);
        chk("pc_head_addr", 64'(waddr_o), 64'd3);
        chk("pc_head_data", 64'(wdata_o), 64'hAA);
        tick();

        // full queue
        drive(0, 0, 0, 1, 5'd1, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 1, 5'd2, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 1, 5'd5, 0, 0, 0, 0, 0);
        chk("full_ready", 64'(ld_issue_ready_o), 64'd0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 32'h11, 0, 0, 5'd5);
        chk("full_ignored", 64'(stall_o), 64'd0);
`ifdef WB_BYPASS_EN
        tick();
        idle(0);
        chk("full_reready", 64'(ld_issue_ready_o), 64'd1);
        tick();
        drive(0, 0, 0, 0, 0, 1, 32'h22, 0, 0, 0); tick();
`else
        tick();
        idle(0);
        chk("full_ret_ready", 64'(ld_issue_ready_o), 64'd0);
        tick();
        idle(0);
        chk("full_reready", 64'(ld_issue_ready_o), 64'd1);
        tick();
        drive(0, 0, 0, 0, 0, 1, 32'h22, 0, 0, 0); tick();
        idle(0); tick();
`endif

        // duplicate destination
        drive(0, 0, 0, 1, 5'd9, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 1, 5'd9, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 1, 32'h100, 5'd9, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 1, 32'h200, 5'd9, 0, 0);
        chk("dup_busy", 64'(stall_o), 64'd1);
        tick();
        idle(5'd9); tick();
        idle(5'd9);
        chk("dup_free", 64'(stall_o), 64'd0);
        chk("dup_final", 64'(rf[9]), 64'h200);
        tick();

        // response latency to an idle port
        drive(0, 0, 0, 1, 5'd6, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 1, 32'h77, 0, 0, 0);
`ifdef WB_BYPASS_EN
        chk("byp_wr", 64'(reg_wr_c), 64'd1);
        chk("byp_data", 64'(wdata_o), 64'h77);
        tick();
`else
        chk("nobyp_wr0", 64'(reg_wr_c), 64'd0);
        tick();
        idle(0);
        chk("nobyp_wr1", 64'(reg_wr_c), 64'd1);
        chk("nobyp_data", 64'(wdata_o), 64'h77);
        tick();
`endif

        // reset with loads pending
        drive(0, 0, 0, 1, 5'd1, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 1, 5'd2, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 5'd1, 5'd2, 0);
        reset = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(ld_issue_ready_o), 64'd1);
        chk("mid_rst_stall", 64'(stall_o), 64'd0);
        mq.delete();
        d_ret = 1'b0; d_push = 1'b0; d_rsp = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // random traffic
        for (int n = 0; n < 400; n++) begin
            logic rsp;
            rsp = (m_first_unfilled() >= 0) && ($urandom_range(0, 1) == 1);
            drive(($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)),
                  rsp, $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter and load scoreboard. Owns the single write port of the integer register file and merges two sources: single-cycle execute results and in-order, variable-latency load responses. Tracks outstanding load destinations so decode can stall on RAW/WAW hazards, and suppresses every write to x0.

## Interface
- `DEPTH`, default 2: maximum number of outstanding loads (tracking entries).
- `XLEN`, default 32: data width.
- `clk`, in, 1: the single clock; all state updates on its rising edge.
- `reset`, in, 1: asynchronous, active-low; clears all state while low.
- `alu_wr_i`, in, 1: execute result valid this cycle.
- `alu_waddr_i`, in, 5: execute destination register.
- `alu_wdata_i`, in, XLEN: execute result.
- `ld_issue_i`, in, 1: load issued this cycle.
- `ld_rd_i`, in, 5: destination register of the issued load.
- `ld_issue_ready_o`, out, 1: a tracking entry is free.
- `ld_rsp_valid_i`, in, 1: load data returns, in issue order.
- `ld_rsp_data_i`, in, XLEN: load data.
- `rs1_i`, `rs2_i`, `rd_i`, in, 5 each: decode-stage operand and destination registers.
- `stall_o`, out, 1: decode must hold.
- `reg_wr_c`, out, 1: register-file write enable.
- `waddr_o`, out, 5: register-file write address.
- `wdata_o`, out, XLEN: register-file write data.

## Operation
- Tracking table has DEPTH entries, each with valid, rd, filled and data fields. It is managed as a circular queue with head, tail and fill pointers.
- Issue:
  - `ld_issue_i && ld_issue_ready_o` allocates the tail entry with rd = `ld_rd_i` and filled = 0.
  - A load with rd = x0 still allocates an entry, so response ordering is preserved, but it never marks a register busy.
  - `ld_issue_i` while not ready is ignored.
- Response: `ld_rsp_valid_i` writes the data into the oldest unfilled valid entry and sets filled. A response with no unfilled entry is dropped and flagged by an assertion.
- Write port priority:
  1. `alu_wr_i` with `alu_waddr_i` != 0: write the execute result.
  2. Otherwise, if the head entry is filled: write its data to its rd and retire the entry.
  3. Otherwise: `reg_wr_c` = 0.
- A filled head entry with rd = x0 retires with `reg_wr_c` = 0. It still occupies the write slot for that cycle.
- `alu_wr_i` to x0 is treated as no ALU write, and the head may drain that cycle.
- Register r is busy when any valid entry has rd == r and r != 0.
- `stall_o` = busy(`rs1_i`) | busy(`rs2_i`) | busy(`rd_i`). It is computed from registered table state only.
- Simultaneous issue and retire in the same cycle are both performed. Issue uses the pre-update ready value.
- Same rd held by two outstanding loads: the register stays busy until both entries retire.
- Reset asserted mid-operation: all entries are invalidated immediately and any in-flight responses are lost. The memory side must also be reset.

## Timing
- Reset values: `ld_issue_ready_o` = 1, `stall_o` = 0, table empty. `reg_wr_c` = 0 whenever `alu_wr_i` = 0.
- `reg_wr_c`, `waddr_o` and `wdata_o` are combinational from the ALU inputs and the head entry. The register file commits the write on the same rising edge.
- ALU result latency: 0 cycles (written at the end of the cycle it is presented).
- Load data latency without bypass: written at earliest 1 cycle after `ld_rsp_valid_i`, and later if the ALU holds the write port.
- `stall_o` deasserts the cycle after the last matching entry retires.
- `ld_issue_ready_o` deasserts the cycle after the DEPTH-th allocation and reasserts the cycle after a retire.

## Configuration
- `WB_BYPASS_EN` defined:
  - Condition: `ld_rsp_valid_i` targets the head entry, the head is unfilled, and there is no ALU write.
  - Effect: the response data is driven straight to the write port and the entry retires that same cycle (0-cycle load latency).
- `WB_BYPASS_EN` undefined: all load data passes through the table, giving a minimum 1-cycle latency.

## Structure
- Package `wb_pkg`:
  - `wb_entry_t` struct: valid, filled, rd[4:0], data[XLEN-1:0].
  - Default DEPTH and XLEN constants.
  - Pointer-width localparam derived as $clog2(DEPTH).
- Sub-module `wb_track_q`: the tracking queue, including pointers, fill logic and the busy-match vector output (32 bits). Arbitration and stall logic stay in `wb_arbiter`.

## Test plan
- ALU only: `alu_wr_i`=1, waddr=5, wdata=0xDEADBEEF → same cycle `reg_wr_c`=1, `waddr_o`=5, `wdata_o`=0xDEADBEEF. Repeat with waddr=0 → `reg_wr_c`=0.
- Load RAW stall: issue load to x7; next cycle `rs1_i`=7 → `stall_o`=1. Response 0x1234 two cycles later → x7 written with 0x1234; `stall_o`=0 the following cycle.
- Port conflict: head filled (x3 = 0xAA) while `alu_wr_i` writes x4 = 0x55 for 3 cycles → only x4 writes occur; x3 = 0xAA is written in the first cycle `alu_wr_i`=0.
- Full: DEPTH=2, issue loads to x1 and x2 → `ld_issue_ready_o`=0 and a third issue is ignored. One retire → ready=1 the next cycle.
- Duplicate rd: two loads to x9 → x9 stays busy until the second retire, and the final value is the second response.
- Bypass and reset:
  - With `WB_BYPASS_EN`: a response 0x77 for head x6 while the ALU is idle → written the same cycle. Without the macro → written one cycle later.
  - `reset` low with 2 entries pending → ready=1 and `stall_o`=0 immediately.
